// File: rtl/bus_ram_responder.sv
// bus_ram_responder
//   Byte-wide RAM target on the Beaker8 CPU bus. It decodes one 16 KB window
//   from address[15:14], waits WAIT_STATES cycles, then performs the access
//   and pulses ready for one cycle.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   read     read request (level, held until ready)
//   write    write request (level, held until ready)
//   address  byte address from the initiator
//   dataIn   write data from the initiator
//   dataOut  read data to the initiator
//   dataOe   1 = dataOut is valid and may drive the shared bus
//   ready    one-cycle completion pulse
//   error    one-cycle pulse when read and write were both high
module bus_ram_responder #(
    parameter logic [1:0] BASE_SEL    = 2'b01,
    parameter int         ADDR_BITS   = 14,
    parameter int         WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] address,
    input  logic [7:0]  dataIn,
    output logic [7:0]  dataOut,
    output logic        dataOe,
    output logic        ready,
    output logic        error
);

    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [1:0] OP_R   = 2'd0;
    localparam logic [1:0] OP_W   = 2'd1;
    localparam logic [1:0] OP_BAD = 2'd2;

    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
            $error("bus_ram_responder: WAIT_STATES must be 0..15");
        end
    endgenerate

    // Request captured in IDLE; everything after capture works from this copy.
    typedef struct packed {
        logic [1:0]           op;
        logic [ADDR_BITS-1:0] addr;
        logic [7:0]           data;
    } req_t;

    logic [1:0] state;
    logic [3:0] cnt;
    req_t       req;
    logic       sel;
    logic       do_access;
    logic [7:0] mem [DEPTH];

    assign sel       = (read | write) && (address[15:14] == BASE_SEL);
    assign do_access = (state == S_WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            req     <= '0;
            dataOut <= 8'h00;
            dataOe  <= 1'b0;
            ready   <= 1'b0;
            error   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel) begin
                        req.op   <= (read && write) ? OP_BAD : (read ? OP_R : OP_W);
                        req.addr <= address[ADDR_BITS-1:0];
                        req.data <= dataIn;
                        cnt      <= WS4;
                        dataOe   <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ready <= 1'b1;
                        state <= S_DONE;
                        case (req.op)
                            OP_R: begin
                                dataOut <= mem[req.addr];
                                dataOe  <= 1'b1;
                            end
                            OP_BAD: begin
                                dataOut <= 8'hFF;
                                dataOe  <= 1'b1;
                                error   <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DONE: begin
                    ready <= 1'b0;
                    error <= 1'b0;
                    // A request still held here goes to HOLD so it cannot
                    // start a second transaction.
                    state <= (read || write) ? S_HOLD : S_IDLE;
                end
                S_HOLD: begin
                    if (!read && !write) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage has no reset. A reset during WAIT forces IDLE, so do_access
    // never fires for the aborted request.
    always_ff @(posedge clk) begin
        if (do_access && req.op == OP_W) mem[req.addr] <= req.data;
    end

endmodule

// File: doc/bus_ram_responder.md
Name: bus_ram_responder

Overview:
- Byte-wide read/write RAM target on the Beaker8 CPU bus. It is the responder end of the CPU's read/write/address/data interface.
- Decodes one 16 KB window from the top two address bits, inserts a configurable number of wait states, and performs the access.
- Signals completion with a one-cycle ready pulse.
- Sits beside the boot ROM in the top level as the first writable memory region.

Parameters:
- BASE_SEL, 2'b01, value of address[15:14] that selects this block (default window 0x4000-0x7FFF).
- ADDR_BITS, 14, number of low address bits used; depth = 2**ADDR_BITS bytes.
- WAIT_STATES, 2, extra cycles between request capture and access (0..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- read  input  1  initiator read request, level, held until ready
- write  input  1  initiator write request, level, held until ready
- address  input  16  byte address from initiator
- dataIn  input  8  write data from initiator (CPU dataOut)
- dataOut  output  8  read data to initiator
- dataOe  output  1  1 = dataOut valid and may drive the shared data bus
- ready  output  1  one-cycle completion pulse
- error  output  1  one-cycle pulse: protocol violation (read and write both high)

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE; ready=0; error=0; dataOe=0; dataOut=8'h00; wait counter=0.
  - RAM contents are not cleared.
- Selected request: (read|write) && address[15:14]==BASE_SEL.
- IDLE:
  - On an edge with a selected request, latch address[ADDR_BITS-1:0], dataIn, and op (R, W, or BAD if read&&write).
  - Load counter=WAIT_STATES, go to WAIT.
  - Unselected or absent requests are ignored and the state stays IDLE.
  - dataOe drops to 0 on entering WAIT.
- WAIT:
  - Edge with counter>0: counter-1.
  - Edge with counter==0: perform the access and go to DONE. On the same edge set ready=1.
  - R: dataOut<=mem[addr], dataOe<=1.
  - W: mem[addr]<=latched data, dataOe stays 0.
  - BAD: no memory access, dataOut<=8'hFF, dataOe<=1, error<=1.
- Latency: request sampled at edge E0 -> ready high after edge E0+WAIT_STATES+1, for exactly one cycle.
- DONE:
  - Next edge clears ready and error.
  - If read==0 && write==0 -> IDLE, else -> HOLD.
- HOLD:
  - Waits until read==0 && write==0 is sampled, then -> IDLE.
  - Guarantees one transaction per request assertion; a held request never re-triggers.
- dataOut/dataOe after a read stay valid through DONE/HOLD/IDLE until the next selected request is captured.
- Address, dataIn, read and write changes after capture (WAIT) are ignored; latched values are used.
- Read-after-write to the same address in back-to-back transactions returns the new data.
- Reset mid-WAIT: access not performed, memory unchanged, outputs return to reset values immediately (async).
- Address bits above ADDR_BITS within the window are ignored; the address wraps modulo 2**ADDR_BITS.
- Counter width is 4 bits; WAIT_STATES>15 is a parameter error and is flagged at elaboration.

Test Plan:
- Reset low mid-sim with WAIT_STATES=2 -> ready=0, error=0, dataOe=0, dataOut=8'h00 without waiting for a clock edge.
- Write 8'hA5 to 0x4123, drop request after ready; then read 0x4123 -> ready exactly 3 edges after each capture, dataOut=8'hA5, dataOe=1.
- Read at 0x8000 (unselected) held 10 cycles -> no ready, state stays IDLE, dataOe=0.
- Read request held high for 8 cycles after ready -> exactly one ready pulse, no second transaction; next read after deassert completes normally.
- read=write=1 at 0x4000 -> error and ready pulse together, dataOut=8'hFF, mem[0x0000] unchanged.
- Write 8'h3C to 0x4010 with reset asserted during WAIT -> later read of 0x4010 returns the prior contents, not 8'h3C. Second run with WAIT_STATES=0: ready after 1 edge from capture.
